data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single data port of the 16-bit-wide dual-port block RAM between two byte-wide requesters: the CPU data port (m0) and the program loader/debug port (m1). The instruction port is outside this block. Every access runs as a sequenced transaction. Byte writes are performed as an explicit read-modify-write of the containing 16-bit word, so only the addressed byte changes. The block sits between the requesters and the RAM's data-side port (`ada`/`dina`/`douta`/`wrea`).

## Interface
Parameters:
- `PRIORITY_MODE`, default 0: 0 = round-robin between m0 and m1; 1 = m1 has fixed priority.

Ports:
- `clock`  in  1  Single clock for all logic.
- `reset`  in  1  Asynchronous, active-low reset.
- `m0_req`  in  1  CPU request. Hold high with fields stable until `m0_ready`.
- `m0_addr`  in  16  CPU byte address.
- `m0_wdata`  in  8  CPU write byte.
- `m0_we`  in  1  1 = write, 0 = read.
- `m0_ready`  out  1  One-cycle completion pulse for m0.
- `m0_rdata`  out  8  m0 read byte. Valid from the `m0_ready` cycle; held until the next m0 read completes.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_ready`, `m1_rdata`: same widths and rules as the m0 ports, for the loader.
- `ram_addr`  out  15  Word address to the RAM: latched byte address [15:1].
- `ram_wdata`  out  16  Merged write word.
- `ram_we`  out  1  RAM write enable.
- `ram_rdata`  in  16  RAM read word. Synchronous, 1-cycle latency.
- `busy`  out  1  High in any state other than IDLE.

## Operation
- The FSM has five states: IDLE, READ, CAPTURE, WRITE, DONE.
- **IDLE**
  - If any `req` is high, arbitrate and latch the grant id, addr, wdata and we.
  - Go to READ.
  - With no request, stay in IDLE.
- **READ**
  - Drive `ram_addr` = latched addr[15:1] with `ram_we` = 0.
- **CAPTURE**
  - Register `ram_rdata` into the word buffer.
  - If we = 1, go to WRITE; otherwise go to DONE.
- **WRITE**
  - Drive `ram_we` = 1.
  - `ram_wdata` = {buf[15:8], wdata} when addr[0] = 0; {wdata, buf[7:0]} when addr[0] = 1.
  - Go to DONE.
- **DONE**
  - Pulse the granted `mX_ready`.
  - For a read, `mX_rdata` = buf[7:0] when addr[0] = 0, buf[15:8] when addr[0] = 1. For a write, `mX_rdata` is unchanged.
  - Go to IDLE.
- **Arbitration, round-robin (`PRIORITY_MODE` = 0)**
  - Both requesting: grant the one not granted last.
  - One requesting: grant it.
  - The last-grant register updates only in IDLE on a grant.
- **Arbitration, fixed (`PRIORITY_MODE` = 1)**
  - m1 wins whenever `m1_req` is high.
- Requester fields are latched in IDLE; changes after the grant are ignored.
- A requester must drop `req` in the cycle after its `ready`, unless it is issuing a new transaction. IDLE re-samples `req`.
- The non-granted requester waits with `ready` low; it is never dropped.
- Outside WRITE: `ram_we` = 0 and `ram_wdata` = buf.
- `ram_addr` holds the latched word address from READ through DONE.

## Timing
- Request seen high in IDLE at cycle 0:
  - READ at cycle 1.
  - CAPTURE at cycle 2.
  - Read: `ready` at cycle 3.
  - Write: `ram_we` at cycle 3, `ready` at cycle 4.
- Throughput: one read per 4 cycles, one write per 5 cycles, including IDLE.
- Reset values:
  - State = IDLE.
  - `m0_ready` = `m1_ready` = 0, `m0_rdata` = `m1_rdata` = 0.
  - `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0, buf = 0.
  - `busy` = 0.
  - Last grant = m1, so m0 wins the first tie.
- Reset asserted mid-transaction: abort immediately, because reset is asynchronous.
  - `ram_we` drops in the same cycle.
  - No `ready` is issued, and no partial or late write occurs after release.
- Requests arriving in READ, CAPTURE, WRITE or DONE are not arbitrated until the next IDLE.
- A read of a word just written by the preceding transaction returns the new data, since that WRITE completes before the next READ.
- Address wrap: `m0_addr` = 16'hFFFF maps to word 15'h7FFF, high byte. There is no special case.

## Test plan
- **Byte-merge write:** preload word 0x0010 = 16'hABCD. m0 writes 8'h5A to addr 16'h0021 → `ram_we` pulses once with `ram_wdata` = 16'h5ACD. A following m0 read of 16'h0020 returns 8'hCD; a read of 16'h0021 returns 8'h5A.
- **Read latency:** m0 reads 16'h0000 holding 16'h1234 → `m0_ready` 3 cycles after the IDLE sample, with `m0_rdata` = 8'h34. `ram_we` stays 0 throughout.
- **Round-robin tie** (`PRIORITY_MODE` = 0): m0 and m1 both request continuously from reset → grants alternate m0, m1, m0, m1. Each `ready` pulses exactly once per transaction.
- **Fixed priority** (`PRIORITY_MODE` = 1): `m1_req` held high continuously → m0 is never granted. When m1 drops, m0 is granted in the next IDLE.
- **Reset mid-write:** assert `reset` low during CAPTURE of an m1 write → no `ram_we`. The RAM word is unchanged, all outputs are at reset values, and after release the state is IDLE.
- **Field change after grant:** m0 changes `m0_addr` from 16'h0002 to 16'h0004 during READ → the transaction uses word 1, and word 2 is untouched.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates two byte-wide requesters onto the 16-bit data port of the block RAM.
// Each access is a sequenced transaction; byte writes are read-modify-write of the word.
//   state   | meaning
//   IDLE    | arbitrate, latch grant and request fields
//   READ    | word address presented to RAM, ram_we low
//   CAPTURE | RAM word registered into buf
//   WRITE   | merged word written back
//   DONE    | ready pulse to granted requester
module data_mem_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  input  logic        m0_we,
  output logic        m0_ready,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_we,
  output logic        m1_ready,
  output logic [7:0]  m1_rdata,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        gnt_q, last_gnt_q, gnt_nxt, any_req;
  logic [15:0] addr_q, buf_q;
  logic [7:0]  wdata_q, rd_byte;
  logic        we_q;

  assign any_req  = m0_req | m1_req;
  assign ram_addr = addr_q[15:1];
  assign rd_byte  = addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0];

  // Grant id: 0 = m0, 1 = m1
  always_comb begin
    gnt_nxt = m1_req;
    if (PRIORITY_MODE == 0 && m0_req && m1_req) begin
      gnt_nxt = ~last_gnt_q;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_wdata = buf_q;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    if (any_req) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = we_q ? WRITE : DONE;
      WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = addr_q[0] ? {wdata_q, buf_q[7:0]} : {buf_q[15:8], wdata_q};
        state_nxt = DONE;
      end
      DONE: begin
        m0_ready  = ~gnt_q;
        m1_ready  = gnt_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      buf_q      <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt_q      <= gnt_nxt;
        last_gnt_q <= gnt_nxt;
        addr_q     <= gnt_nxt ? m1_addr  : m0_addr;
        wdata_q    <= gnt_nxt ? m1_wdata : m0_wdata;
        we_q       <= gnt_nxt ? m1_we    : m0_we;
      end
      // Read byte is registered alongside buf so it is valid in the DONE cycle
      if (state == CAPTURE) begin
        buf_q <= ram_rdata;
        if (!we_q) begin
          if (gnt_q) m1_rdata <= rd_byte;
          else       m0_rdata <= rd_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance for the starvation/priority checks.
module tb_data_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        a_m0_req = 1'b0, a_m0_we = 1'b0, a_m1_req = 1'b0, a_m1_we = 1'b0;
  logic [15:0] a_m0_addr = '0, a_m1_addr = '0;
  logic [7:0]  a_m0_wdata = '0, a_m1_wdata = '0;
  logic        a_m0_ready, a_m1_ready, a_ram_we, a_busy;
  logic [7:0]  a_m0_rdata, a_m1_rdata;
  logic [14:0] a_ram_addr;
  logic [15:0] a_ram_wdata;
  logic [15:0] a_ram_rdata = '0;

  logic        b_m0_req = 1'b0, b_m1_req = 1'b0;
  logic        b_m0_ready, b_m1_ready, b_ram_we, b_busy;
  logic [7:0]  b_m0_rdata, b_m1_rdata;
  logic [14:0] b_ram_addr;
  logic [15:0] b_ram_wdata;
  logic [15:0] b_ram_rdata = '0;

  data_mem_arbiter #(.PRIORITY_MODE(0)) dut_a (
    .clock(clock), .reset(reset),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_we(a_m0_we),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_we(a_m1_we),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we),
    .ram_rdata(a_ram_rdata), .busy(a_busy)
  );

  data_mem_arbiter #(.PRIORITY_MODE(1)) dut_b (
    .clock(clock), .reset(reset),
    .m0_req(b_m0_req), .m0_addr(16'h0000), .m0_wdata(8'h00), .m0_we(1'b0),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_addr(16'h0002), .m1_wdata(8'h00), .m1_we(1'b0),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
    .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  // RAM models: synchronous read, 1-cycle latency; preload port for dut_a's RAM
  logic [15:0] mem_a [0:32767];
  logic [15:0] mem_b [0:32767];
  logic [15:0] shadow [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
    a_ram_rdata <= mem_a[a_ram_addr];
  end

  always @(posedge clock) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
    b_ram_rdata <= mem_b[b_ram_addr];
  end

  typedef struct packed {logic id; logic rd; logic [7:0] data;} exp_t;
  typedef struct packed {logic [14:0] addr; logic [15:0] word;} wexp_t;
  exp_t  exp_q[$];
  wexp_t wexp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    b_m0_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_t  e;
      wexp_t w;
      if (a_m0_ready && a_m1_ready) check("dual_ready", 32'(a_m1_ready), 32'(1'b0));
      if (a_m0_ready || a_m1_ready) begin
        if (exp_q.size() == 0) check("unexpected_ready", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("grant_id", 32'(a_m1_ready), 32'(e.id));
          if (e.rd) check("rdata", 32'(e.id ? a_m1_rdata : a_m0_rdata), 32'(e.data));
        end
      end
      if (a_ram_we) begin
        if (wexp_q.size() == 0) check("unexpected_we", 32'(wexp_q.size()), 32'd1);
        else begin
          w = wexp_q.pop_front();
          check("we_addr", 32'(a_ram_addr), 32'(w.addr));
          check("we_data", 32'(a_ram_wdata), 32'(w.word));
        end
      end
      if (b_m0_ready) b_m0_cnt++;
    end
  end

  task automatic preload(input logic [14:0] w, input logic [15:0] v);
    @(posedge clock); #1;
    pl_en = 1'b1; pl_addr = w; pl_data = v;
    @(posedge clock); #1;
    pl_en = 1'b0;
    shadow[w] = v;
  endtask

  task automatic push_exp(input logic id, input logic [15:0] a, input logic [7:0] d, input logic we);
    logic [15:0] w;
    w = shadow[a[15:1]];
    if (we) begin
      if (a[0]) w[15:8] = d;
      else      w[7:0]  = d;
      shadow[a[15:1]] = w;
      wexp_q.push_back({a[15:1], w});
      exp_q.push_back({id, 1'b0, 8'h00});
    end else begin
      exp_q.push_back({id, 1'b1, a[0] ? w[15:8] : w[7:0]});
    end
  endtask

  task automatic drive(input logic id, input logic [15:0] a, input logic [7:0] d, input logic we);
    if (id) begin a_m1_addr = a; a_m1_wdata = d; a_m1_we = we; a_m1_req = 1'b1; end
    else    begin a_m0_addr = a; a_m0_wdata = d; a_m0_we = we; a_m0_req = 1'b1; end
  endtask

  task automatic wait_ready(input logic id, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (id ? a_m1_ready : a_m0_ready) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("ready_timeout", 32'(lat), 32'd0);
  endtask

  task automatic txn(input logic id, input logic [15:0] a, input logic [7:0] d, input logic we,
                     input int want_lat);
    int lat;
    push_exp(id, a, d, we);
    @(posedge clock); #1;
    drive(id, a, d, we);
    wait_ready(id, lat);
    check("latency", 32'(lat), 32'(want_lat));
    @(posedge clock); #1;
    if (id) a_m1_req = 1'b0;
    else    a_m0_req = 1'b0;
  endtask

  task automatic check_reset_a();
    check("rst_busy",     32'(a_busy),      32'd0);
    check("rst_m0_ready", 32'(a_m0_ready),  32'd0);
    check("rst_m1_ready", 32'(a_m1_ready),  32'd0);
    check("rst_m0_rdata", 32'(a_m0_rdata),  32'd0);
    check("rst_m1_rdata", 32'(a_m1_rdata),  32'd0);
    check("rst_ram_we",   32'(a_ram_we),    32'd0);
    check("rst_ram_addr", 32'(a_ram_addr),  32'd0);
    check("rst_ram_wdata",32'(a_ram_wdata), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lat;
    bit seen_m1;
    #2;
    check_reset_a();

    // Round-robin tie from reset: both hold requests, grants must alternate
    preload(15'h0080, 16'h1122);
    preload(15'h0101, 16'h3344);
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b0, 16'h0100, 8'h00, 1'b0);
      push_exp(1'b1, 16'h0203, 8'h00, 1'b0);
    end
    drive(1'b0, 16'h0100, 8'h00, 1'b0);
    drive(1'b1, 16'h0203, 8'h00, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge clock);
      if (a_m0_ready || a_m1_ready) cnt++;
    end
    check("tie_count", 32'(cnt), 32'd4);
    @(posedge clock); #1;
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;

    // Byte-merge write then readback of both bytes
    preload(15'h0010, 16'hABCD);
    txn(1'b0, 16'h0021, 8'h5A, 1'b1, 4);
    txn(1'b0, 16'h0020, 8'h00, 1'b0, 3);
    txn(1'b0, 16'h0021, 8'h00, 1'b0, 3);

    // Read latency, m1 write/read, address wrap
    preload(15'h0000, 16'h1234);
    txn(1'b0, 16'h0000, 8'h00, 1'b0, 3);
    preload(15'h0020, 16'h0000);
    txn(1'b1, 16'h0040, 8'h99, 1'b1, 4);
    txn(1'b1, 16'h0040, 8'h00, 1'b0, 3);
    preload(15'h7FFF, 16'hBEEF);
    txn(1'b1, 16'hFFFF, 8'h00, 1'b0, 3);

    // Address change after grant must be ignored
    preload(15'h0001, 16'h5555);
    preload(15'h0002, 16'h6666);
    push_exp(1'b0, 16'h0002, 8'h77, 1'b1);
    @(posedge clock); #1;
    drive(1'b0, 16'h0002, 8'h77, 1'b1);
    @(posedge clock); #1;
    a_m0_addr = 16'h0004;
    wait_ready(1'b0, lat);
    check("fc_latency", 32'(lat), 32'd3);
    @(posedge clock); #1;
    a_m0_req = 1'b0;
    check("fc_word2_untouched", 32'(mem_a[2]), 32'h6666);
    txn(1'b0, 16'h0002, 8'h00, 1'b0, 3);
    txn(1'b0, 16'h0004, 8'h00, 1'b0, 3);

    // Reset asserted in CAPTURE of an m1 write
    preload(15'h0030, 16'hC0DE);
    @(posedge clock); #1;
    drive(1'b1, 16'h0061, 8'hEE, 1'b1);
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check_reset_a();
    a_m1_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("rst_word_unchanged", 32'(mem_a[15'h0030]), 32'hC0DE);
    check("rst_idle_after", 32'(a_busy), 32'd0);
    txn(1'b1, 16'h0061, 8'h00, 1'b0, 3);

    // Fixed priority instance: m1 held high starves m0
    @(posedge clock); #1;
    b_m0_req = 1'b1;
    b_m1_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 3; i++) begin
      @(negedge clock);
      if (b_m1_ready) cnt++;
    end
    check("fixed_m1_count", 32'(cnt), 32'd3);
    check("fixed_m0_starved", 32'(b_m0_cnt), 32'd0);
    @(posedge clock); #1;
    b_m1_req = 1'b0;
    lat = -1;
    seen_m1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (b_m1_ready) seen_m1 = 1'b1;
      if (b_m0_ready) begin
        lat = i;
        break;
      end
    end
    check("fixed_m0_latency", 32'(lat), 32'd3);
    check("fixed_no_m1_after_drop", 32'(seen_m1), 32'd0);
    @(posedge clock); #1;
    b_m0_req = 1'b0;

    repeat (4) @(posedge clock);
    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("wexp_left", 32'(wexp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
